// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared constants and types for the instruction fetch stage.
//
// Contents:
//   INSTR_W           instruction word width
//   RESET_PC_DEFAULT  default PC loaded on reset (word aligned)
//   fetch_entry_t     one queue entry: {instr, pc, pc_plus4}, 96 bits
//   word_align()      clears the byte-offset bits of an address
//
// Optional feature macro used by this slice: FETCH_ALIGN_CHECK_EN
// (misaligned redirect raises a sticky fault and halts fetch).
package fetch_unit_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue -- parameterised synchronous FIFO between imem response and decode.
//
// Parameters:
//   DEPTH   number of entries (power of two, >= 2)
//   DATA_W  entry width
// Ports:
//   clk, reset      clock, asynchronous active-high reset (pointers/count only)
//   push, push_data write one entry (caller guarantees no overflow)
//   pop             remove head (caller guarantees not empty)
//   flush           empty the queue; overrides push and pop
//   count           current occupancy
//   head            entry at the read pointer
module fetch_queue #(
  parameter  int DEPTH  = 2,
  parameter  int DATA_W = 96,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- MIPS instruction fetch stage.
//
// Owns the PC, issues word reads to instruction memory (1-cycle read latency)
// and delivers {instr, pc, pc+4} to decode over a valid/ready handshake.
// Redirects from execute flush the queue and toggle an epoch so that the
// wrong-path word still in flight is discarded.
//
// Parameters:
//   RESET_PC     PC loaded on reset (word aligned)
//   QUEUE_DEPTH  instruction queue entries (power of two, >= 2)
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   imem_req, imem_addr        read request / word-aligned byte address
//   imem_rdata                 read data, valid the cycle after imem_req
//   redirect_valid/_pc         PC replacement from execute
//   out_valid/out_ready        handshake to decode
//   out_instr/out_pc/out_pc_plus4  head entry (zero while out_valid is low)
//   fault                      sticky misaligned-redirect flag
//                              (only when FETCH_ALIGN_CHECK_EN is defined)
//
// Macro: FETCH_ALIGN_CHECK_EN -- misaligned redirect sets fault and halts
// fetch. Undefined: redirect_pc[1:0] is ignored and fetch continues.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               fault
`endif
);

  localparam int              CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W:0]  DEPTH_L = (CNT_W+1)'(QUEUE_DEPTH);

  logic [31:0]      pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic             epoch;
  logic             inflight_epoch;
  logic             halted;

  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head;
  fetch_entry_t     push_entry;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occ;

  assign out_valid = (q_count != '0);
  assign pop       = out_valid && out_ready;

  // Occupancy after this cycle, counting the response landing now.
  assign occ = {1'b0, q_count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};

  assign imem_req  = !reset && !redirect_valid && !halted && (occ < DEPTH_L);
  assign imem_addr = pc;

  // A redirect this cycle flushes, so the arriving word is dropped too.
  assign push       = inflight && (inflight_epoch == epoch) && !redirect_valid;
  assign push_entry = '{instr: imem_rdata, pc: inflight_pc, pc_plus4: inflight_pc + 32'd4};

`ifdef FETCH_ALIGN_CHECK_EN
  assign halted = fault;
`else
  assign halted = 1'b0;
`endif

  // Issue stage: PC, in-flight tracking and redirect handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc             <= RESET_PC;
      inflight       <= 1'b0;
      epoch          <= 1'b0;
      inflight_epoch <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault          <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc       <= word_align(redirect_pc);
      epoch    <= ~epoch;
      inflight <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) fault <= 1'b1;
`endif
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc             <= pc + 32'd4;
        inflight_epoch <= epoch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) inflight_pc <= pc;
  end

  // Response stage: word enters the queue; outputs come only from queue storage.
  fetch_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

  assign out_instr    = out_valid ? q_head.instr    : '0;
  assign out_pc       = out_valid ? q_head.pc       : '0;
  assign out_pc_plus4 = out_valid ? q_head.pc_plus4 : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit with a 1-cycle-latency
// instruction memory model. Inputs are driven 2 time units after the rising
// edge and outputs sampled 1 unit later.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fault          (fault)
`endif
  );

  // Memory contents: the two test-plan words, elsewhere a tag of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2010_0005;
      32'h0000_0004: return 32'h2011_0007;
      default:       return {8'hC0, a[23:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  // Leaves the bench in cycle 0 (reset just released), outputs settled.
  task automatic do_reset(input logic rdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = rdy;
    tick;
    tick;
    reset = 1'b0;
    settle;
  endtask

  initial begin
    int reqs;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    tick;
    settle;

    // Reset state
    check_vec("rst_req",    32'(imem_req),  32'd0);
    check_vec("rst_valid",  32'(out_valid), 32'd0);
    check_vec("rst_instr",  out_instr,      32'h0);
    check_vec("rst_pc",     out_pc,         32'h0);
    check_vec("rst_pc4",    out_pc_plus4,   32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check_vec("rst_fault",  32'(fault),     32'd0);
`endif

    // Reset release, streaming with out_ready high
    do_reset(1'b1);
    check_vec("c0_req",   32'(imem_req), 32'd1);
    check_vec("c0_addr",  imem_addr,     32'h0);
    tick; settle;
    check_vec("c1_valid", 32'(out_valid), 32'd0);
    check_vec("c1_addr",  imem_addr,      32'h4);
    tick; settle;
    check_vec("c2_valid", 32'(out_valid), 32'd1);
    check_vec("c2_instr", out_instr,      32'h2010_0005);
    check_vec("c2_pc",    out_pc,         32'h0);
    check_vec("c2_pc4",   out_pc_plus4,   32'h4);
    tick; settle;
    check_vec("c3_pc",    out_pc,         32'h4);
    check_vec("c3_instr", out_instr,      32'h2011_0007);

    // Decode stall: out_ready low for cycles 0..6
    do_reset(1'b0);
    reqs = 0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        tick; settle;
      end
      reqs += 32'(imem_req);
      if (c >= 2) begin
        check_vec("stall_valid", 32'(out_valid), 32'd1);
        check_vec("stall_pc",    out_pc,         32'h0);
      end
    end
    check_vec("stall_reqs", 32'(reqs), 32'd2);

    // Release: issue resumes in the cycle of the first pop
    tick; out_ready = 1'b1; settle;
    check_vec("rel_pc0",   out_pc,         32'h0);
    check_vec("rel_req",   32'(imem_req),  32'd1);
    check_vec("rel_addr",  imem_addr,      32'h8);
    tick; settle;
    check_vec("rel_pc4",   out_pc,         32'h4);
    check_vec("rel_v4",    32'(out_valid), 32'd1);

    // Redirect to 0x40 while popping pc 0x08 and with 0x0C in flight
    tick; redirect_valid = 1'b1; redirect_pc = 32'h40; settle;
    check_vec("rd_pc8",    out_pc,         32'h8);
    check_vec("rd_v8",     32'(out_valid), 32'd1);
    check_vec("rd_noreq",  32'(imem_req),  32'd0);
    tick; redirect_valid = 1'b0; settle;
    check_vec("rd1_valid", 32'(out_valid), 32'd0);
    check_vec("rd1_req",   32'(imem_req),  32'd1);
    check_vec("rd1_addr",  imem_addr,      32'h40);
    tick; out_ready = 1'b0; settle;
    check_vec("rd2_valid", 32'(out_valid), 32'd0);
    tick; settle;
    check_vec("rd3_valid", 32'(out_valid), 32'd1);
    check_vec("rd3_pc",    out_pc,         32'h40);
    check_vec("rd3_instr", out_instr,      32'hC000_0040);
    check_vec("rd3_pc4",   out_pc_plus4,   32'h44);
    tick; settle;
    check_vec("q2_pc",     out_pc,         32'h40);

    // Asynchronous reset mid-cycle with two entries queued
    #1 reset = 1'b1;
    #1;
    check_vec("ar_valid",  32'(out_valid), 32'd0);
    check_vec("ar_req",    32'(imem_req),  32'd0);
    check_vec("ar_pc",     out_pc,         32'h0);
    #1 reset = 1'b0; out_ready = 1'b1;
    #1;
    check_vec("ar_rreq",   32'(imem_req),  32'd1);
    check_vec("ar_raddr",  imem_addr,      32'h0);
    tick; tick; settle;
    check_vec("ar_c2pc",   out_pc,         32'h0);
    check_vec("ar_c2ins",  out_instr,      32'h2010_0005);

    // PC wrap through 0xFFFFFFFC
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle;
    check_vec("wr_noreq",  32'(imem_req), 32'd0);
    tick; redirect_valid = 1'b0; settle;
    check_vec("wr_addr0",  imem_addr,     32'hFFFF_FFFC);
    check_vec("wr_req",    32'(imem_req), 32'd1);
    tick; settle;
    check_vec("wr_addr1",  imem_addr,     32'h0);
    tick; settle;
    check_vec("wr_pc",     out_pc,        32'hFFFF_FFFC);
    check_vec("wr_pc4",    out_pc_plus4,  32'h0);
    check_vec("wr_instr",  out_instr,     32'hC0FF_FFFC);
    tick; settle;
    check_vec("wr_nextpc", out_pc,        32'h0);
    check_vec("wr_nextin", out_instr,     32'h2010_0005);

    // Misaligned redirect to 0x42
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h42; settle;
    tick; redirect_valid = 1'b0; settle;
`ifdef FETCH_ALIGN_CHECK_EN
    check_vec("mis_fault", 32'(fault), 32'd1);
    reqs = 0;
    for (int c = 0; c < 5; c++) begin
      reqs += 32'(imem_req);
      tick; settle;
    end
    check_vec("mis_reqs",  32'(reqs),      32'd0);
    check_vec("mis_valid", 32'(out_valid), 32'd0);
    check_vec("mis_fault2", 32'(fault),    32'd1);
`else
    check_vec("mis_req",   32'(imem_req), 32'd1);
    check_vec("mis_addr",  imem_addr,     32'h40);
    tick; tick; settle;
    check_vec("mis_pc",    out_pc,        32'h40);
    check_vec("mis_pc4",   out_pc_plus4,  32'h44);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS core: owns the program counter, issues word reads to instruction memory and delivers `{instruction, pc, pc+4}` to decode through a valid/ready handshake. It sits between instruction memory and the decode/register-file stage, and accepts PC redirects (branch, jump, jr) from the execute stage. A small instruction queue decouples memory latency from decode stalls.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word aligned.
- `QUEUE_DEPTH`, 2, instruction queue entries; power of two, at least 2.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  32  byte address of the requested word, always word aligned.
- `imem_rdata`  in  32  instruction word; valid exactly one cycle after `imem_req`.
- `redirect_valid`  in  1  replace the PC this cycle.
- `redirect_pc`  in  32  new PC.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  decode accepts the head.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  head PC.
- `out_pc_plus4`  out  32  head PC + 4, modulo 2^32.
- `fault`  out  1  misaligned redirect; present only with `FETCH_ALIGN_CHECK_EN`.

## Operation
- Registers: `pc`, `inflight` (1 bit), `inflight_pc`, `epoch` (1 bit), `inflight_epoch`, and the queue.
- Issue rule: `imem_req = !redirect_valid && (count + inflight - pop) < QUEUE_DEPTH`, where `pop = out_valid && out_ready`. On issue, `imem_addr = pc`, `pc <= pc + 4` (wraps at 2^32), `inflight <= 1`, and the current `pc` and `epoch` are latched with it.
- Response: in the cycle after an issue, if `inflight_epoch == epoch`, push `{imem_rdata, inflight_pc, inflight_pc + 4}`; otherwise drop it.
- Handshake: the head is consumed when `out_valid && out_ready`. While the head is not consumed, `out_*` are held stable. A push and a pop in the same cycle both take effect. The issue rule guarantees the queue never overflows.
- Redirect:
  - `pc <= redirect_pc`, queue cleared, `epoch` toggled, so the in-flight wrong-path word is discarded.
  - A pop in the redirect cycle still completes.
  - A redirect overrides any issue in the same cycle.
  - Back-to-back redirects: the last one wins.
- Reset, including mid-operation: `pc = RESET_PC`, queue empty, `inflight = 0`, `epoch = 0`. Outputs: `imem_req = 0`, `out_valid = 0`, `out_instr/out_pc/out_pc_plus4 = 0`, `fault = 0`.

## Timing
- Cycle 0 = first edge after `reset` falls: `imem_req = 1` with `imem_addr = RESET_PC`. Data arrives in cycle 1 and `out_valid = 1` in cycle 2.
- Issue-to-delivery latency: 2 cycles.
- Sustained throughput with `out_ready` held high: one instruction per cycle.
- Redirect asserted in cycle R:
  - `out_valid = 0` from R+1.
  - Request at `redirect_pc` issued in R+1.
  - Its instruction is visible in R+3.
- Decode stall: at most `QUEUE_DEPTH` words are buffered. Issue resumes in the cycle of the first pop.
- No combinational path from `imem_rdata` to `out_*`. `imem_req` depends combinationally on `out_ready` and `redirect_valid` only.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fault` (sticky until reset).
  - `pc` is loaded with `redirect_pc & ~3`.
  - The queue is flushed, and no further requests are issued.
- Not defined: the `fault` port is absent, `redirect_pc[1:0]` is ignored (forced to 0), and fetch continues.

## Structure
- Shared constants in `_const.v`: `RESET_PC` default value and the instruction-word width.
- The `FETCH_ALIGN_CHECK_EN` macro is also declared in `_const.v`.
- Sub-module `fetch_queue`: parameterised synchronous FIFO (depth, width).
  - Ports: push, pop, flush, count, head.
  - `fetch_unit` instantiates it with width 96.

## Test plan
- Reset release, memory holds 0x20100005, 0x20110007 at addresses 0 and 4, `out_ready = 1`:
  - cycle 2: `out_instr = 32'h20100005`, `out_pc = 0`, `out_pc_plus4 = 4`.
  - cycle 3: `out_pc = 4`.
- `out_ready = 0` for 5 cycles:
  - at most 2 requests are issued, and `out_*` stay at pc 0.
  - After release, pcs 0, 4, 8 are delivered on consecutive cycles with no gap or duplicate.
- Redirect to 0x40 while a request for 0x0C is in flight:
  - the 0x0C word is never delivered.
  - The next delivered `out_pc` is 0x40, three cycles after the redirect.
- Redirect in the same cycle as a pop of pc 0x08: the pop completes, and the next `out_pc` is `redirect_pc`.
- `reset` asserted asynchronously mid-stream with 2 entries queued: `out_valid` and `imem_req` go to 0 immediately, and fetch restarts at `RESET_PC`.
- PC wrap: redirect to 0xFFFFFFFC, then delivered `out_pc_plus4 = 0` and the next `out_pc = 0`.
- With `FETCH_ALIGN_CHECK_EN`: redirect to 0x42 gives `fault = 1` and no `imem_req` until reset.
